// File: rtl/display_board_pkg.sv
// Shared types, register map and timing helpers for the display-board button scanner.
package display_board_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_COMMIT
  } scan_state_e;

  localparam logic [1:0] REG_STATE  = 2'd0;
  localparam logic [1:0] REG_CHANGE = 2'd1;
  localparam logic [1:0] REG_IRQ_EN = 2'd2;
  localparam logic [1:0] REG_SCANS  = 2'd3;

  function automatic int unsigned half_cycles(input int unsigned clk_hz,
                                              input int unsigned shift_hz);
    return clk_hz / (2 * shift_hz);
  endfunction

  function automatic int unsigned scan_cycles(input int unsigned clk_hz,
                                              input int unsigned scan_hz);
    return clk_hz / scan_hz;
  endfunction

endpackage

// File: rtl/display_button_debounce.sv
// Word-level debouncer: commits the raw scan word after DEBOUNCE_SCANS identical scans.
module display_button_debounce #(
  parameter int unsigned NBITS          = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] raw,
  input  logic             commit,
  output logic [NBITS-1:0] state,
  output logic [NBITS-1:0] changed_c
);

  localparam int unsigned SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

  logic [NBITS-1:0] prev_raw_q;
  logic [SW-1:0]    stable_q;
  logic [SW-1:0]    stable_d;
  logic             take_c;

  // Saturating count of consecutive identical scans
  always_comb begin
    stable_d = '0;
    if (raw == prev_raw_q) begin
      stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + SW'(1);
    end
  end

  assign take_c    = commit && (stable_d == STABLE_MAX);
  assign changed_c = take_c ? (state ^ raw) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_raw_q <= '0;
      stable_q   <= '0;
      state      <= '0;
    end else if (commit) begin
      prev_raw_q <= raw;
      stable_q   <= stable_d;
      if (take_c) state <= raw;
    end
  end

endmodule

// File: rtl/display_button_scanner.sv
// Scans the display-board PISO button chain, debounces it and exposes it over Avalon-MM with IRQ.
module display_button_scanner
  import display_board_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned SHIFT_HZ       = 1_000_000,
  parameter int unsigned SCAN_HZ        = 1_000,
  parameter int unsigned NBITS          = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned ACTIVE_LOW     = 1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  output logic             shift_clkin,
  output logic             shift_load,
  input  logic             shift_out,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic             irq,
  output logic [NBITS-1:0] buttons
);

  localparam int unsigned HALF        = half_cycles(CLK_HZ, SHIFT_HZ);
  localparam int unsigned SCAN_CYCLES = scan_cycles(CLK_HZ, SCAN_HZ);
  localparam int unsigned BW          = (NBITS > 1) ? $clog2(NBITS) : 1;

  generate
    if (HALF < 1 || NBITS < 1 || NBITS > 32 || DEBOUNCE_SCANS < 1 ||
        (2 + 2 * NBITS) * HALF >= SCAN_CYCLES) begin : g_bad_cfg
      $error("display_button_scanner: scan does not fit in the scan period");
    end
  endgenerate

  scan_state_e      state_q, state_d;
  logic [31:0]      timer_q;
  logic [31:0]      hcnt_q, hcnt_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic             shift_clkin_d, shift_load_d;
  logic             tick_c, half_done_c, commit_c;
  logic [NBITS-1:0] raw_c, chg_c, w1c_c;
  logic [NBITS-1:0] change_q, irq_en_q;
  logic [31:0]      scan_count_q;
  logic [31:0]      rd_mux_c;
  logic             unused_wdata;

  assign tick_c       = (timer_q == SCAN_CYCLES - 1);
  assign half_done_c  = (hcnt_q == HALF - 1);
  assign commit_c     = (state_q == ST_COMMIT);
  assign raw_c        = (ACTIVE_LOW != 0) ? ~shreg_q : shreg_q;
  assign unused_wdata = ^avs_writedata;

  // Scan sequencer: every non-idle phase except COMMIT lasts HALF cycles
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q + 32'd1;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    case (state_q)
      ST_IDLE: begin
        hcnt_d = '0;
        if (tick_c) state_d = ST_LOAD;
      end
      ST_LOAD: if (half_done_c) begin
        state_d = ST_SETTLE;
        hcnt_d  = '0;
      end
      ST_SETTLE: if (half_done_c) begin
        state_d  = ST_CLK_LO;
        hcnt_d   = '0;
        bitcnt_d = '0;
      end
      ST_CLK_LO: if (half_done_c) begin
        state_d = ST_CLK_HI;
        hcnt_d  = '0;
        shreg_d = NBITS'({shreg_q, shift_out});
      end
      ST_CLK_HI: if (half_done_c) begin
        hcnt_d   = '0;
        bitcnt_d = bitcnt_q + BW'(1);
        state_d  = (bitcnt_q == BW'(NBITS - 1)) ? ST_COMMIT : ST_CLK_LO;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        hcnt_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        hcnt_d  = '0;
      end
    endcase
    shift_load_d  = (state_d != ST_LOAD);
    shift_clkin_d = (state_d == ST_CLK_HI);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      hcnt_q      <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      shift_clkin <= 1'b0;
      shift_load  <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= tick_c ? '0 : timer_q + 32'd1;
      hcnt_q      <= hcnt_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      shift_clkin <= shift_clkin_d;
      shift_load  <= shift_load_d;
    end
  end

  display_button_debounce #(
    .NBITS          (NBITS),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .raw       (raw_c),
    .commit    (commit_c),
    .state     (buttons),
    .changed_c (chg_c)
  );

  assign w1c_c = (avs_write && avs_address == REG_CHANGE) ? avs_writedata[NBITS-1:0] : '0;

  always_comb begin
    rd_mux_c = '0;
    case (avs_address)
      REG_STATE:  rd_mux_c = 32'(buttons);
      REG_CHANGE: rd_mux_c = 32'(change_q);
      REG_IRQ_EN: rd_mux_c = 32'(irq_en_q);
      default:    rd_mux_c = scan_count_q;
    endcase
  end

  // Register file; a new change bit outranks a simultaneous clear
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      change_q     <= '0;
      irq_en_q     <= '0;
      scan_count_q <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      change_q <= (change_q & ~w1c_c) | chg_c;
      if (avs_write && avs_address == REG_IRQ_EN) irq_en_q <= avs_writedata[NBITS-1:0];
      if (commit_c) scan_count_q <= scan_count_q + 32'd1;
      irq <= |(change_q & irq_en_q);
      if (avs_read) avs_readdata <= rd_mux_c;
    end
  end

endmodule
